// File: rtl/led_out_seq.sv
// Sequencer and BRAM arbiter for the led_out formatter: runs one led_out job per
// accepted result, lends the character BRAM to a readout between jobs, and blanks it on command.
module led_out_seq #(
    parameter int         BCD_WIDTH = 60,
    parameter int         TIMEOUT   = 1024,
    parameter logic [7:0] BLANK     = 8'h20
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [BCD_WIDTH-1:0] res_bcd,
    input  logic                 res_signed,
    input  logic                 res_fixed,
    input  logic                 clear,
    output logic                 lo_rst,
    output logic                 lo_ce,
    output logic [BCD_WIDTH-1:0] lo_bcd,
    output logic                 lo_signed,
    output logic                 lo_fixed,
    input  logic [3:0]           lo_addr,
    input  logic [7:0]           lo_data,
    input  logic                 lo_we,
    input  logic                 lo_done,
    input  logic                 rd_req,
    output logic                 rd_gnt,
    input  logic [3:0]           rd_addr,
    output logic [3:0]           bram_addr,
    output logic [7:0]           bram_data,
    output logic                 bram_we,
    output logic                 busy,
    output logic                 refresh,
    output logic                 err
);

    localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_RUN,
        S_FIN,
        S_ABORT,
        S_CLR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic [TW-1:0] to_cnt;
    logic [3:0]    clr_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        lo_rst    = 1'b1;
        lo_ce     = 1'b0;
        busy      = 1'b1;
        refresh   = 1'b0;
        bram_addr = 4'h0;
        bram_data = 8'h00;
        bram_we   = 1'b0;
        // The RST_N term keeps res_ready low while the block is held in reset.
        res_ready = RST_N && (state == S_IDLE) && !rd_gnt && !clear;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (rd_gnt) begin
                    bram_addr = rd_addr;
                end else if (clear) begin
                    state_nxt = S_CLR;
                end else if (res_valid) begin
                    state_nxt = S_LRST;
                    accept    = 1'b1;
                end
            end
            S_LRST: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                lo_rst    = 1'b0;
                lo_ce     = 1'b1;
                bram_addr = lo_addr;
                bram_data = lo_data;
                bram_we   = lo_we;
                if (lo_done) begin
                    state_nxt = S_FIN;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ABORT;
                end
            end
            S_FIN: begin
                refresh   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                state_nxt = S_IDLE;
            end
            S_CLR: begin
                bram_addr = clr_cnt;
                bram_data = BLANK;
                bram_we   = 1'b1;
                // A clear finishes through FIN so it shares the single refresh pulse.
                if (clr_cnt == 4'hF) begin
                    state_nxt = S_FIN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_gnt    <= 1'b0;
            err       <= 1'b0;
            to_cnt    <= '0;
            clr_cnt   <= 4'h0;
            lo_bcd    <= '0;
            lo_signed <= 1'b0;
            lo_fixed  <= 1'b0;
        end else begin
            // A granted reader keeps the BRAM until it lets go; a fresh request loses to clear/result.
            if (state == S_IDLE) begin
                rd_gnt <= rd_gnt ? rd_req : (rd_req && !clear && !res_valid);
            end

            if (accept) begin
                lo_bcd    <= res_bcd;
                lo_signed <= res_signed;
                lo_fixed  <= res_fixed;
                err       <= 1'b0;
            end else if (state == S_RUN && state_nxt == S_ABORT) begin
                err <= 1'b1;
            end

            to_cnt  <= (state == S_RUN && state_nxt == S_RUN) ? to_cnt + 1'b1 : '0;
            clr_cnt <= (state == S_CLR) ? clr_cnt + 1'b1 : 4'h0;
        end
    end

endmodule

// File: tb/tb_led_out_seq.sv
// Bench for led_out_seq: reset/decision vector table, directed corner sequences and a
// randomized mix of jobs, clears and reads checked against transaction-level expectations.
module tb_led_out_seq;

    localparam int TO = 16;
    localparam logic [7:0] BLK = 8'h20;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [59:0] res_bcd = '0;
    logic        res_signed = 1'b0;
    logic        res_fixed = 1'b0;
    logic        clear = 1'b0;
    logic        lo_rst;
    logic        lo_ce;
    logic [59:0] lo_bcd;
    logic        lo_signed;
    logic        lo_fixed;
    logic [3:0]  lo_addr = 4'h0;
    logic [7:0]  lo_data = 8'h00;
    logic        lo_we = 1'b0;
    logic        lo_done = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_gnt;
    logic [3:0]  rd_addr = 4'h0;
    logic [3:0]  bram_addr;
    logic [7:0]  bram_data;
    logic        bram_we;
    logic        busy;
    logic        refresh;
    logic        err;

    int   total = 0;
    int   bad = 0;
    logic m_err = 1'b0;

    led_out_seq #(.BCD_WIDTH(60), .TIMEOUT(TO), .BLANK(BLK)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .res_valid(res_valid), .res_ready(res_ready), .res_bcd(res_bcd),
        .res_signed(res_signed), .res_fixed(res_fixed), .clear(clear),
        .lo_rst(lo_rst), .lo_ce(lo_ce), .lo_bcd(lo_bcd), .lo_signed(lo_signed),
        .lo_fixed(lo_fixed), .lo_addr(lo_addr), .lo_data(lo_data), .lo_we(lo_we),
        .lo_done(lo_done), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr),
        .bram_addr(bram_addr), .bram_data(bram_data), .bram_we(bram_we),
        .busy(busy), .refresh(refresh), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic clr;
        logic vld;
        logic req;
        logic rdy;
        logic busy_n;
        logic gnt_n;
        logic we_n;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [19:0] mk(logic rdy, logic lrst, logic ce, logic bsy, logic rfr,
                                       logic er, logic gnt, logic we, logic [3:0] a, logic [7:0] d);
        return {rdy, lrst, ce, bsy, rfr, er, gnt, we, a, d};
    endfunction

    function automatic logic [19:0] obs();
        return {res_ready, lo_rst, lo_ce, busy, refresh, err, rd_gnt, bram_we, bram_addr, bram_data};
    endfunction

    function automatic logic [59:0] rand60();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[59:0];
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] got;
        got = obs();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got rdy,lrst,ce,busy,rfr,err,gnt,we,addr,data=%h want=%h",
                     name, $time, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        #1;
        check("reset", mk(0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00));
        check_val("reset_latch", {2'b0, lo_bcd, lo_signed, lo_fixed}, 64'h0);
        m_err = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        nxt();
    endtask

    task automatic idle_cycle();
        res_valid = 1'b0; clear = 1'b0; rd_req = 1'b0;
        lo_done = 1'($urandom); lo_we = 1'($urandom);
        lo_addr = 4'($urandom); lo_data = 8'($urandom); rd_addr = 4'($urandom);
        smp();
        check("idle", mk(1, 1, 0, 0, 0, m_err, 0, 0, 4'h0, 8'h00));
        nxt();
        lo_done = 1'b0; lo_we = 1'b0;
    endtask

    // done_at: RUN cycle index (0-based) in which lo_done is raised; >= TO means never.
    task automatic do_job(input logic [59:0] bcd, input logic sg, input logic fx, input int done_at);
        int n;
        res_valid = 1'b1; res_bcd = bcd; res_signed = sg; res_fixed = fx;
        clear = 1'b0; rd_req = 1'b0;
        smp();
        check("accept", mk(1, 1, 0, 0, 0, m_err, 0, 0, 4'h0, 8'h00));
        nxt();
        res_valid = 1'b0; res_bcd = rand60(); res_signed = 1'($urandom); res_fixed = 1'($urandom);
        lo_done = 1'($urandom); lo_we = 1'($urandom);
        m_err = 1'b0;
        smp();
        check("lrst", mk(0, 1, 0, 1, 0, 0, 0, 0, 4'h0, 8'h00));
        nxt();
        n = (done_at < TO) ? done_at + 1 : TO;
        for (int k = 0; k < n; k++) begin
            lo_done = (k == done_at);
            lo_addr = 4'($urandom); lo_data = 8'($urandom); lo_we = 1'($urandom);
            res_valid = 1'($urandom); clear = 1'($urandom); rd_req = 1'($urandom);
            smp();
            check("run", mk(0, 0, 1, 1, 0, 0, 0, lo_we, lo_addr, lo_data));
            check_val("run_latch", {2'b0, lo_bcd, lo_signed, lo_fixed}, {2'b0, bcd, sg, fx});
            nxt();
        end
        res_valid = 1'b0; clear = 1'b0; rd_req = 1'b0;
        lo_done = 1'($urandom); lo_we = 1'($urandom);
        smp();
        if (done_at < TO) begin
            check("fin", mk(0, 1, 0, 1, 1, 0, 0, 0, 4'h0, 8'h00));
        end else begin
            m_err = 1'b1;
            check("abort", mk(0, 1, 0, 1, 0, 1, 0, 0, 4'h0, 8'h00));
        end
        nxt();
        lo_done = 1'b0; lo_we = 1'b0;
    endtask

    task automatic do_clear(input logic with_valid);
        clear = 1'b1; res_valid = with_valid; res_bcd = rand60(); rd_req = 1'b0;
        smp();
        check("clr_req", mk(0, 1, 0, 0, 0, m_err, 0, 0, 4'h0, 8'h00));
        nxt();
        for (int i = 0; i < 16; i++) begin
            clear = (i < 15) ? 1'($urandom) : 1'b0;
            rd_req = (i < 15) ? 1'($urandom) : 1'b0;
            lo_we = 1'($urandom); lo_done = 1'($urandom);
            smp();
            check("clr_wr", mk(0, 1, 0, 1, 0, m_err, 0, 1, 4'(i), BLK));
            nxt();
        end
        clear = 1'b0; rd_req = 1'b0; lo_we = 1'b0; lo_done = 1'b0;
        smp();
        check("clr_fin", mk(0, 1, 0, 1, 1, m_err, 0, 0, 4'h0, 8'h00));
        nxt();
    endtask

    // rd_req held for len cycles; with_valid raises res_valid during the grant.
    task automatic do_read(input int len, input logic with_valid);
        rd_req = 1'b1; res_valid = 1'b0; clear = 1'b0; rd_addr = 4'($urandom);
        smp();
        check("rd_req", mk(1, 1, 0, 0, 0, m_err, 0, 0, 4'h0, 8'h00));
        nxt();
        for (int i = 1; i <= len; i++) begin
            rd_req = (i < len);
            rd_addr = 4'($urandom);
            res_valid = with_valid;
            clear = (i < len) ? 1'($urandom) : 1'b0;
            lo_we = 1'($urandom);
            smp();
            check("rd_gnt", mk(0, 1, 0, 0, 0, m_err, 1, 0, rd_addr, 8'h00));
            nxt();
        end
        rd_req = 1'b0; clear = 1'b0; lo_we = 1'b0;
        if (!with_valid) begin
            smp();
            check("rd_drop", mk(1, 1, 0, 0, 0, m_err, 0, 0, 4'h0, 8'h00));
            nxt();
        end
    endtask

    initial begin
        vecs[0] = '{clr:0, vld:0, req:0, rdy:1, busy_n:0, gnt_n:0, we_n:0};
        vecs[1] = '{clr:0, vld:0, req:1, rdy:1, busy_n:0, gnt_n:1, we_n:0};
        vecs[2] = '{clr:0, vld:1, req:0, rdy:1, busy_n:1, gnt_n:0, we_n:0};
        vecs[3] = '{clr:0, vld:1, req:1, rdy:1, busy_n:1, gnt_n:0, we_n:0};
        vecs[4] = '{clr:1, vld:0, req:0, rdy:0, busy_n:1, gnt_n:0, we_n:1};
        vecs[5] = '{clr:1, vld:1, req:0, rdy:0, busy_n:1, gnt_n:0, we_n:1};
        vecs[6] = '{clr:1, vld:0, req:1, rdy:0, busy_n:1, gnt_n:0, we_n:1};
        vecs[7] = '{clr:1, vld:1, req:1, rdy:0, busy_n:1, gnt_n:0, we_n:1};

        for (int i = 0; i < 8; i++) begin
            apply_reset();
            clear = vecs[i].clr; res_valid = vecs[i].vld; rd_req = vecs[i].req;
            smp();
            check_val("vec_ready", 64'(res_ready), 64'(vecs[i].rdy));
            nxt();
            clear = 1'b0; res_valid = 1'b0; rd_req = 1'b0;
            smp();
            check_val("vec_next", 64'({busy, rd_gnt, bram_we}),
                      64'({vecs[i].busy_n, vecs[i].gnt_n, vecs[i].we_n}));
            nxt();
        end

        apply_reset();
        do_job(60'h123456789, 1'b0, 1'b0, 5);
        idle_cycle();
        do_read(5, 1'b1);
        do_job(rand60(), 1'b0, 1'b1, 2);
        do_clear(1'b1);
        do_job(rand60(), 1'b1, 1'b0, 0);
        do_job(rand60(), 1'b0, 1'b0, TO + 3);
        idle_cycle();
        do_job(rand60(), 1'b0, 1'b0, TO - 1);
        do_job(rand60(), 1'b0, 1'b0, 3);
        do_job(60'h4560, 1'b1, 1'b1, 7);

        // Reset while RUN is in progress.
        res_valid = 1'b1; res_bcd = rand60();
        smp(); nxt();
        res_valid = 1'b0;
        smp(); nxt();
        lo_we = 1'b0; lo_addr = 4'h0; lo_data = 8'h00; lo_done = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("midrun", mk(0, 0, 1, 1, 0, 0, 0, 0, 4'h0, 8'h00));
            nxt();
        end
        smp(); #2;
        apply_reset();
        do_job(rand60(), 1'b1, 1'b1, 4);

        // Reset while a clear is in progress.
        clear = 1'b1;
        smp(); nxt();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("midclr", mk(0, 1, 0, 1, 0, m_err, 0, 1, 4'(i), BLK));
            nxt();
        end
        smp(); #2;
        apply_reset();
        do_job(rand60(), 1'b0, 1'b1, 1);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: do_job(rand60(), 1'($urandom), 1'($urandom), int'($urandom_range(0, TO + 3)));
                1: begin
                    if ($urandom_range(0, 1) == 1) begin
                        do_clear(1'b1);
                        do_job(rand60(), 1'($urandom), 1'($urandom), int'($urandom_range(0, TO - 1)));
                    end else begin
                        do_clear(1'b0);
                    end
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) begin
                        do_read(int'($urandom_range(1, 6)), 1'b1);
                        do_job(rand60(), 1'($urandom), 1'($urandom), int'($urandom_range(0, TO + 1)));
                    end else begin
                        do_read(int'($urandom_range(1, 6)), 1'b0);
                    end
                end
                default: idle_cycle();
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
